yrv_board_io: RTL and testbench

Parametrised board I/O conditioner between the Yrv core and the DE2 pins. Synchronises switches, synchronises and debounces active-low push-keys, and produces per-key press pulses plus sticky press events. Drives NUM_HEX registered active-low seven-segment digits from a packed nibble bus, with per-digit blanking. It replaces the raw pin-to-core wiring in the top level.

---
 rtl/yrv_board_io_pkg.sv | 21 ++
 rtl/yrv_board_io_debounce.sv | 60 ++++++
 rtl/yrv_board_io.sv | 147 ++++++++++++++
 tb/tb_yrv_board_io.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yrv_board_io_pkg.sv
// rtl/yrv_board_io_pkg.sv - shared constants and seven-segment decode for yrv_board_io
//
// Purpose: blank pattern and the 16-entry active-low segment table used by the
// hex digit registers. Segment bit 0 = a ... bit 6 = g, 0 = lit.
// Ports: none (package).

package yrv_board_io_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n holds the pattern for nibble value n (index 0 is the rightmost).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    return SEG_TABLE[value];
  endfunction

endpackage

// File: rtl/yrv_board_io_debounce.sv
// rtl/yrv_board_io_debounce.sv - two-flop synchroniser and debouncer for one active-low key
//
// Purpose: synchronises one raw key and accepts a new level only after it has
// differed from the accepted level for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clock    in   sole clock
//   reset_n  in   synchronous active-low reset
//   key_n_i  in   raw key, 0 = pressed, asynchronous
//   deb_o    out  debounced key, 0 = pressed (resets to 1, released)

module yrv_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic key_n_i,
  output logic deb_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             deb_q;
  logic             deb_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Any cycle where the synchronised key agrees with the accepted level
  // restarts the count, so a glitch forces a full new stable window.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/yrv_board_io.sv
// rtl/yrv_board_io.sv - DE2 board I/O conditioner: keys, switches and seven-segment digits
//
// Purpose: synchronises switches, debounces active-low keys into level, press
// pulse and sticky event outputs, and drives registered active-low hex digits
// with per-digit blanking. Optional blink feature: YRV_BOARD_IO_BLINK_EN.
// Ports:
//   clock        in   sole clock
//   reset_n      in   synchronous active-low reset
//   key_n_i      in   raw keys, 0 = pressed
//   sw_i         in   raw switches
//   key_clr_i    in   per-key sticky event clear
//   hex_value_i  in   nibble per digit, digit d at [4d+3:4d]
//   hex_blank_i  in   1 = digit dark
//   hex_blink_i  in   1 = digit blinks (YRV_BOARD_IO_BLINK_EN only)
//   key_level_o  out  debounced level, 1 = pressed
//   key_press_o  out  one-cycle pulse per accepted press
//   key_event_o  out  sticky press flag
//   sw_o         out  synchronised switches
//   hex_o        out  active-low segments, digit d at [7d+6:7d]

module yrv_board_io
  import yrv_board_io_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned NUM_SW          = 18,
  parameter int unsigned NUM_HEX         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned BLINK_CYCLES    = 12500000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_KEYS-1:0]  key_n_i,
  input  logic [NUM_SW-1:0]    sw_i,
  input  logic [NUM_KEYS-1:0]  key_clr_i,
  input  logic [4*NUM_HEX-1:0] hex_value_i,
  input  logic [NUM_HEX-1:0]   hex_blank_i,
`ifdef YRV_BOARD_IO_BLINK_EN
  input  logic [NUM_HEX-1:0]   hex_blink_i,
`endif
  output logic [NUM_KEYS-1:0]  key_level_o,
  output logic [NUM_KEYS-1:0]  key_press_o,
  output logic [NUM_KEYS-1:0]  key_event_o,
  output logic [NUM_SW-1:0]    sw_o,
  output logic [7*NUM_HEX-1:0] hex_o
);

  if (DEBOUNCE_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_param_check
    $error("yrv_board_io: DEBOUNCE_CYCLES and BLINK_CYCLES must be >= 1");
  end

  logic [NUM_KEYS-1:0]  deb;
  logic [NUM_KEYS-1:0]  deb_prev_q;
  logic [NUM_KEYS-1:0]  press_q;
  logic [NUM_KEYS-1:0]  press_d;
  logic [NUM_KEYS-1:0]  event_q;
  logic [NUM_KEYS-1:0]  event_d;
  logic [NUM_SW-1:0]    sw_meta_q;
  logic [NUM_SW-1:0]    sw_sync_q;
  logic [7*NUM_HEX-1:0] hex_q;
  logic [7*NUM_HEX-1:0] hex_d;
  logic [NUM_HEX-1:0]   blink_mask;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    yrv_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock   (clock),
      .reset_n (reset_n),
      .key_n_i (key_n_i[k]),
      .deb_o   (deb[k])
    );
  end

`ifdef YRV_BOARD_IO_BLINK_EN
  localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  logic [BLINK_W-1:0] blink_cnt_q;
  logic [BLINK_W-1:0] blink_cnt_d;
  logic               phase_q;
  logic               phase_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // Phase 0 is the visible half; blanking is ORed in below so it always wins.
  assign blink_mask = hex_blink_i & {NUM_HEX{phase_q}};
`else
  assign blink_mask = '0;
`endif

  // deb is active-low, so a press is a 1->0 fall of the accepted level.
  // Press is registered one cycle after the fall; set beats clear on events.
  always_comb begin
    press_d = deb_prev_q & ~deb;
    event_d = press_q | (event_q & ~key_clr_i);
  end

  always_comb begin
    hex_d = '0;
    for (int d = 0; d < NUM_HEX; d++) begin
      hex_d[7*d +: 7] = (hex_blank_i[d] | blink_mask[d]) ? SEG_BLANK
                                                         : hex_to_seg(hex_value_i[4*d +: 4]);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      deb_prev_q <= '1;
      press_q    <= '0;
      event_q    <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      hex_q      <= {NUM_HEX{SEG_BLANK}};
    end else begin
      deb_prev_q <= deb;
      press_q    <= press_d;
      event_q    <= event_d;
      sw_meta_q  <= sw_i;
      sw_sync_q  <= sw_meta_q;
      hex_q      <= hex_d;
    end
  end

  assign key_level_o = ~deb;
  assign key_press_o = press_q;
  assign key_event_o = event_q;
  assign sw_o        = sw_sync_q;
  assign hex_o       = hex_q;

endmodule

// File: tb/tb_yrv_board_io.sv
// tb/tb_yrv_board_io.sv - self-checking bench for yrv_board_io (DEBOUNCE_CYCLES=4, BLINK_CYCLES=8)

module tb_yrv_board_io;

  localparam int NK = 4;
  localparam int NS = 18;
  localparam int NH = 4;
  localparam int DB = 4;
  localparam int BL = 8;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [NK-1:0]     key_n_i;
  logic [NS-1:0]     sw_i;
  logic [NK-1:0]     key_clr_i;
  logic [4*NH-1:0]   hex_value_i;
  logic [NH-1:0]     hex_blank_i;
`ifdef YRV_BOARD_IO_BLINK_EN
  logic [NH-1:0]     hex_blink_i;
`endif
  logic [NK-1:0]     key_level_o;
  logic [NK-1:0]     key_press_o;
  logic [NK-1:0]     key_event_o;
  logic [NS-1:0]     sw_o;
  logic [7*NH-1:0]   hex_o;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [NK-1:0]   khist[$];
  logic [NS-1:0]   shist[$];
  logic [NK-1:0]   m_deb;
  logic [NK-1:0]   m_fell_prev;
  logic [NK-1:0]   m_press;
  logic [NK-1:0]   m_event;
  logic [NS-1:0]   m_sw;
  logic [7*NH-1:0] m_hex;
  int              m_edges;

  logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clock = ~clock;

  yrv_board_io #(
    .NUM_KEYS        (NK),
    .NUM_SW          (NS),
    .NUM_HEX         (NH),
    .DEBOUNCE_CYCLES (DB),
    .BLINK_CYCLES    (BL)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .key_n_i     (key_n_i),
    .sw_i        (sw_i),
    .key_clr_i   (key_clr_i),
    .hex_value_i (hex_value_i),
    .hex_blank_i (hex_blank_i),
`ifdef YRV_BOARD_IO_BLINK_EN
    .hex_blink_i (hex_blink_i),
`endif
    .key_level_o (key_level_o),
    .key_press_o (key_press_o),
    .key_event_o (key_event_o),
    .sw_o        (sw_o),
    .hex_o       (hex_o)
  );

  // A key change is accepted once the synchronised key (raw delayed two
  // samples) has disagreed with the accepted level for DB samples in a row.
  task automatic model_edge();
    logic [NK-1:0] fell;
    logic [NK-1:0] s;
    logic          stable;
    logic          dark;
    if (!reset_n) begin
      khist.delete();
      shist.delete();
      for (int i = 0; i < DB + 2; i++) begin
        khist.push_back('1);
        shist.push_back('0);
      end
      m_deb = '1; m_fell_prev = '0; m_press = '0; m_event = '0;
      m_sw = '0; m_hex = '1; m_edges = 0;
    end else begin
      khist.push_back(key_n_i);
      shist.push_back(sw_i);
      if (khist.size() > DB + 8) void'(khist.pop_front());
      if (shist.size() > DB + 8) void'(shist.pop_front());
      fell = '0;
      for (int k = 0; k < NK; k++) begin
        stable = 1'b1;
        for (int j = 0; j < DB; j++) begin
          s = khist[khist.size() - 3 - j];
          if (s[k] == m_deb[k]) stable = 1'b0;
        end
        if (stable) begin
          fell[k]  = m_deb[k];
          m_deb[k] = ~m_deb[k];
        end
      end
      m_event     = m_press | (m_event & ~key_clr_i);
      m_press     = m_fell_prev;
      m_fell_prev = fell;
      m_sw        = shist[shist.size() - 2];
      for (int d = 0; d < NH; d++) begin
        dark = hex_blank_i[d];
`ifdef YRV_BOARD_IO_BLINK_EN
        if (hex_blink_i[d] && ((m_edges / BL) % 2 == 1)) dark = 1'b1;
`endif
        m_hex[7*d +: 7] = dark ? 7'h7F : seg_ref[hex_value_i[4*d +: 4]];
      end
      m_edges++;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    key_n_i     = NK'($urandom);
    sw_i        = NS'($urandom);
    key_clr_i   = NK'($urandom);
    hex_value_i = 16'($urandom);
    hex_blank_i = NH'($urandom);
`ifdef YRV_BOARD_IO_BLINK_EN
    hex_blink_i = NH'($urandom);
`endif
    repeat (3) tick();
    n_vec++; if (key_level_o !== '0) begin n_err++; $display("FAIL reset_level got %h want 0", key_level_o); end
    n_vec++; if (key_press_o !== '0) begin n_err++; $display("FAIL reset_press got %h want 0", key_press_o); end
    n_vec++; if (key_event_o !== '0) begin n_err++; $display("FAIL reset_event got %h want 0", key_event_o); end
    n_vec++; if (sw_o !== '0) begin n_err++; $display("FAIL reset_sw got %h want 0", sw_o); end
    n_vec++; if (hex_o !== {NH{7'h7F}}) begin n_err++; $display("FAIL reset_hex got %h want %h", hex_o, {NH{7'h7F}}); end
    key_n_i = '1; sw_i = '0; key_clr_i = '0; hex_value_i = '0; hex_blank_i = '0;
`ifdef YRV_BOARD_IO_BLINK_EN
    hex_blink_i = '0;
`endif
    reset_n = 1'b1;
    tick();
    n_vec++; if (hex_o !== {NH{7'h40}}) begin n_err++; $display("FAIL release_hex got %h want %h", hex_o, {NH{7'h40}}); end
    n_vec++; if (key_level_o !== '0) begin n_err++; $display("FAIL release_level got %h want 0", key_level_o); end
    repeat (DB + 4) tick();
  endtask

  task automatic test_clean_press();
    logic [NK-1:0] exp_level, exp_press, exp_event;
    key_n_i[1] = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      exp_level = (e >= 6) ? 4'b0010 : 4'b0000;
      exp_press = (e == 7) ? 4'b0010 : 4'b0000;
      exp_event = (e >= 8) ? 4'b0010 : 4'b0000;
      n_vec++; if (key_level_o !== exp_level) begin n_err++; $display("FAIL press_level edge %0d got %h want %h", e, key_level_o, exp_level); end
      n_vec++; if (key_press_o !== exp_press) begin n_err++; $display("FAIL press_pulse edge %0d got %h want %h", e, key_press_o, exp_press); end
      n_vec++; if (key_event_o !== exp_event) begin n_err++; $display("FAIL press_event edge %0d got %h want %h", e, key_event_o, exp_event); end
    end
    key_n_i[1] = 1'b1;
    for (int e = 1; e <= DB + 4; e++) begin
      tick();
      n_vec++; if (key_press_o !== '0) begin n_err++; $display("FAIL release_pulse edge %0d got %h want 0", e, key_press_o); end
    end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    logic exp_level;
    for (int e = 1; e <= 12; e++) begin
      key_n_i[0] = (e == 4) ? 1'b1 : 1'b0;
      tick();
      if (key_press_o[0]) pulses++;
      exp_level = (e >= 10);
      n_vec++; if (key_level_o[0] !== exp_level) begin n_err++; $display("FAIL bounce_level edge %0d got %b want %b", e, key_level_o[0], exp_level); end
    end
    n_vec++; if (pulses != 1) begin n_err++; $display("FAIL bounce_pulses got %0d want 1", pulses); end
    key_n_i[0] = 1'b1;
    repeat (DB + 4) tick();
  endtask

  task automatic test_event_clear();
    key_clr_i = 4'b0010;
    tick();
    key_clr_i = '0;
    n_vec++; if (key_event_o !== 4'b0001) begin n_err++; $display("FAIL clear_event got %h want 1", key_event_o); end
    key_n_i[2] = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      key_clr_i = '0;
      if (e == 7) begin
        n_vec++; if (key_press_o !== 4'b0100) begin n_err++; $display("FAIL clr_press got %h want 4", key_press_o); end
        key_clr_i[2] = 1'b1;
      end
      if (e >= 8) begin
        n_vec++; if (key_event_o !== 4'b0101) begin n_err++; $display("FAIL set_wins edge %0d got %h want 5", e, key_event_o); end
      end
    end
    key_n_i[2] = 1'b1;
    repeat (DB + 4) tick();
  endtask

  task automatic test_hex();
    hex_value_i = 16'hA5F8;
    hex_blank_i = 4'b0100;
    tick();
    n_vec++; if (hex_o !== {7'h08, 7'h7F, 7'h0E, 7'h00}) begin n_err++; $display("FAIL hex_a5f8 got %h want %h", hex_o, {7'h08, 7'h7F, 7'h0E, 7'h00}); end
    for (int i = 0; i < 24; i++) begin
      hex_value_i = 16'($urandom);
      hex_blank_i = NH'($urandom_range(0, 3) == 0 ? $urandom : 0);
      tick();
      n_vec++; if (hex_o !== m_hex) begin n_err++; $display("FAIL hex_rand got %h want %h", hex_o, m_hex); end
    end
    hex_value_i = '0;
    hex_blank_i = '0;
    tick();
  endtask

  task automatic test_switches();
    logic [NS-1:0] prev, nxt;
    prev = sw_i;
    nxt  = prev ^ (NS'($urandom) | NS'(1));
    sw_i = nxt;
    tick();
    n_vec++; if (sw_o !== prev) begin n_err++; $display("FAIL sw_lat1 got %h want %h", sw_o, prev); end
    tick();
    n_vec++; if (sw_o !== nxt) begin n_err++; $display("FAIL sw_lat2 got %h want %h", sw_o, nxt); end
  endtask

  task automatic test_reset_mid();
    logic exp_level;
    key_n_i[3] = 1'b0;
    repeat (3) tick();
    reset_n = 1'b0;
    repeat (2) tick();
    n_vec++; if (key_level_o !== '0) begin n_err++; $display("FAIL midrst_level got %h want 0", key_level_o); end
    reset_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_level = (e >= DB + 2);
      n_vec++; if (key_level_o[3] !== exp_level) begin n_err++; $display("FAIL midrst_accept edge %0d got %b want %b", e, key_level_o[3], exp_level); end
    end
    key_n_i[3] = 1'b1;
    repeat (DB + 4) tick();
  endtask

`ifdef YRV_BOARD_IO_BLINK_EN
  task automatic test_blink();
    logic [6:0] exp_d0;
    reset_n = 1'b0;
    tick();
    hex_value_i = '0; hex_blank_i = '0; hex_blink_i = 4'b0001;
    reset_n = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      tick();
      exp_d0 = (((e - 1) / BL) % 2 == 1) ? 7'h7F : 7'h40;
      n_vec++; if (hex_o !== {7'h40, 7'h40, 7'h40, exp_d0}) begin n_err++; $display("FAIL blink edge %0d got %h want %h", e, hex_o, {7'h40, 7'h40, 7'h40, exp_d0}); end
    end
    hex_blank_i = 4'b0010; hex_blink_i = 4'b0010;
    for (int e = 1; e <= 2 * BL; e++) begin
      tick();
      n_vec++; if (hex_o[13:7] !== 7'h7F) begin n_err++; $display("FAIL blank_blink edge %0d got %h want 7f", e, hex_o[13:7]); end
    end
    hex_blank_i = '0; hex_blink_i = '0;
    tick();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      reset_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      for (int k = 0; k < NK; k++) begin
        if ($urandom_range(0, 5) == 0) key_n_i[k] = ~key_n_i[k];
      end
      if ($urandom_range(0, 3) == 0) sw_i = NS'($urandom);
      key_clr_i   = ($urandom_range(0, 7) == 0) ? NK'($urandom) : '0;
      hex_value_i = 16'($urandom);
      hex_blank_i = NH'($urandom);
`ifdef YRV_BOARD_IO_BLINK_EN
      hex_blink_i = NH'($urandom);
`endif
      tick();
      n_vec++; if (key_level_o !== ~m_deb) begin n_err++; $display("FAIL rand_level cyc %0d got %h want %h", i, key_level_o, ~m_deb); end
      n_vec++; if (key_press_o !== m_press) begin n_err++; $display("FAIL rand_press cyc %0d got %h want %h", i, key_press_o, m_press); end
      n_vec++; if (key_event_o !== m_event) begin n_err++; $display("FAIL rand_event cyc %0d got %h want %h", i, key_event_o, m_event); end
      n_vec++; if (sw_o !== m_sw) begin n_err++; $display("FAIL rand_sw cyc %0d got %h want %h", i, sw_o, m_sw); end
      n_vec++; if (hex_o !== m_hex) begin n_err++; $display("FAIL rand_hex cyc %0d got %h want %h", i, hex_o, m_hex); end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_event_clear();
    test_hex();
    test_switches();
    test_reset_mid();
`ifdef YRV_BOARD_IO_BLINK_EN
    test_blink();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
